// File: rtl/latch_if_pkg.sv
// Shared definitions for the D/C latch interface: transmitter states, default
// phase timing and the width helpers used by both transmit and receive sides.
package latch_if_pkg;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_SETUP  = 2'd1,
        TX_STROBE = 2'd2,
        TX_HOLD   = 2'd3
    } tx_state_t;

    localparam int DEF_SETUP = 2;
    localparam int DEF_PULSE = 1;
    localparam int DEF_HOLD  = 2;

    // The phase counter must be able to hold the longest of the three phases.
    function automatic int phase_cnt_width(input int setup, input int pulse, input int hold);
        int longest;
        longest = setup;
        if (pulse > longest) longest = pulse;
        if (hold > longest) longest = hold;
        return $clog2(longest + 1);
    endfunction

    function automatic int bit_idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/latch_strobe_tx_if.sv
// Frame handshake plus serial D/C outputs of the latch strobe transmitter.
interface latch_strobe_tx_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data_in;
    logic             valid;
    logic             ready;
    logic             d;
    logic             c;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output valid,
        input  ready,
        input  d,
        input  c,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  valid,
        output ready,
        output d,
        output c,
        output busy,
        output done
    );
endinterface

// File: rtl/latch_strobe_tx_phase_timer.sv
// Loadable down-counter timing one FSM phase; expire is high once the loaded
// count has run down to zero, so loading N-1 gives an N-cycle phase.
module phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/latch_strobe_tx.sv
// Serialises a parallel word LSB first onto d, framing every bit with a
// setup / strobe / hold sequence on c so a far-end D latch captures it cleanly.
module latch_strobe_tx
    import latch_if_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SETUP = DEF_SETUP,
    parameter int PULSE = DEF_PULSE,
    parameter int HOLD  = DEF_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    latch_strobe_tx_if.slave bus
);

    localparam int CNT_W = phase_cnt_width(SETUP, PULSE, HOLD);
    localparam int IDX_W = bit_idx_width(WIDTH);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             c_q, c_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_expire;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

    // d is taken straight from shift_q[0], so it only moves on the accept and
    // shift edges that enter SETUP, and an async reset clears it immediately.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        c_d       = c_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;

        case (state_q)
            TX_IDLE: begin
                if (bus.valid) begin
                    state_d   = TX_SETUP;
                    shift_d   = bus.data_in;
                    idx_d     = '0;
                    ready_d   = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_value = SETUP_LOAD;
                end
            end
            TX_SETUP: begin
                if (tmr_expire) begin
                    state_d   = TX_STROBE;
                    c_d       = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_value = PULSE_LOAD;
                end
            end
            TX_STROBE: begin
                if (tmr_expire) begin
                    state_d   = TX_HOLD;
                    c_d       = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_value = HOLD_LOAD;
                end
            end
            TX_HOLD: begin
                if (tmr_expire) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = TX_IDLE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = TX_SETUP;
                        idx_d     = idx_q + IDX_W'(1);
                        shift_d   = shift_q >> 1;
                        tmr_load  = 1'b1;
                        tmr_value = SETUP_LOAD;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                c_d     = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = ~ready_q;
    assign bus.c     = c_q;
    assign bus.d     = shift_q[0];
    assign bus.done  = done_q;

    // The strobe is never raised while idle, and done only accompanies ready.
    a_idle_no_strobe : assert property (@(posedge clk) disable iff (rst) ready_q |-> !c_q);
    a_done_with_ready : assert property (@(posedge clk) disable iff (rst) done_q |-> ready_q);

endmodule
